// File: rtl/decoder4_16_seq.sv
// Registered 4-to-16 one-hot decoder with valid/ready handshake.
// Define DECODER_SWEEP_EN to build the walking-one SWEEP mode; otherwise the sweep port is ignored.
module decoder4_16_seq #(
    parameter int unsigned SWEEP_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [3:0]  in_code,
    output logic        in_ready,
    input  logic        sweep,
    output logic [15:0] y,
    output logic [3:0]  y_code,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
`ifdef DECODER_SWEEP_EN
    localparam logic [1:0] SWEEP = 2'd2;
    localparam logic [7:0] DIV_LAST = 8'(SWEEP_DIV - 1);

    logic [3:0] idx;
    logic [7:0] div;
    logic [3:0] idx_nxt;

    assign idx_nxt = idx + 4'd1;
`else
    logic sweep_unused;

    assign sweep_unused = sweep | (SWEEP_DIV == 0);
`endif

    logic [1:0] state;
    logic       accept;

    // in_ready is forced low while reset is being sampled so no code is acknowledged then
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    in_ready = 1'b1;
                HOLD:    in_ready = out_ready;
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            y         <= '0;
            y_code    <= '0;
            out_valid <= 1'b0;
`ifdef DECODER_SWEEP_EN
            idx       <= '0;
            div       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef DECODER_SWEEP_EN
                    if (sweep) begin
                        state     <= SWEEP;
                        y         <= 16'h0001;
                        y_code    <= '0;
                        out_valid <= 1'b1;
                        idx       <= '0;
                        div       <= '0;
                    end else
`endif
                    if (accept) begin
                        state     <= HOLD;
                        y         <= 16'h0001 << in_code;
                        y_code    <= in_code;
                        out_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        if (accept) begin
                            y         <= 16'h0001 << in_code;
                            y_code    <= in_code;
                            out_valid <= 1'b1;
                        end else begin
                            state     <= IDLE;
                            y         <= '0;
                            out_valid <= 1'b0;
                        end
                    end
                end
`ifdef DECODER_SWEEP_EN
                SWEEP: begin
                    if (!sweep) begin
                        state     <= IDLE;
                        y         <= '0;
                        out_valid <= 1'b0;
                        idx       <= '0;
                        div       <= '0;
                    end else if (div == DIV_LAST) begin
                        div    <= '0;
                        idx    <= idx_nxt;
                        y      <= 16'h0001 << idx_nxt;
                        y_code <= idx_nxt;
                    end else begin
                        div <= div + 8'd1;
                    end
                end
`endif
                default: begin
                    state     <= IDLE;
                    y         <= '0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
